// File: rtl/memory_access_stage.sv
// MEM stage of the 16-bit pipeline: issues loads/stores over a req/ack handshake,
// stalls upstream until the access finishes, then hands results to MEM/WB.
module memory_access_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wbs_in,
  input  logic              ni_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              valid_out,
  output logic              wbs_out,
  output logic [DATA_W-1:0] memData_out,
  output logic [DATA_W-1:0] calcData_out,
  output logic              ni_out,
  output logic              mem_err
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                wbs_q, wbs_d;
  logic                ni_q, ni_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   calc_q, calc_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_op_s;

  assign mem_op_s = valid_in & (mem_read_in | mem_write_in);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wbs_q   <= 1'b0;
      ni_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= CNT_ZERO;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      calc_q  <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wbs_q   <= wbs_d;
      ni_q    <= ni_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      calc_q  <= calc_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: latch on accept, wait for ack or timeout, release
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    wbs_d   = wbs_q;
    ni_d    = ni_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    calc_d  = calc_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          addr_d  = alu_result_in[ADDR_W-1:0];
          wdata_d = write_data_in;
          we_d    = mem_write_in;
          wbs_d   = wbs_in;
          ni_d    = ni_in;
          calc_d  = alu_result_in;
          rdata_d = {DATA_W{1'b0}};
          cnt_d   = CNT_ZERO;
          req_d   = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // An ack on the final allowed cycle still counts as success.
        if (mem_ack) begin
          rdata_d = we_q ? {DATA_W{1'b0}} : mem_rdata;
          cnt_d   = CNT_ZERO;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = {DATA_W{1'b0}};
          cnt_d   = CNT_ZERO;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  // MEM/WB-facing outputs: pass-through, bubble, or latched result
  always_comb begin
    stall        = 1'b0;
    valid_out    = 1'b0;
    wbs_out      = 1'b0;
    ni_out       = 1'b0;
    memData_out  = {DATA_W{1'b0}};
    calcData_out = {DATA_W{1'b0}};
    if (rst) begin
      stall = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op_s) begin
            stall = 1'b1;
          end else begin
            valid_out    = valid_in;
            wbs_out      = wbs_in;
            ni_out       = ni_in;
            calcData_out = alu_result_in;
          end
        end
        ACCESS: begin
          stall = 1'b1;
        end
        DONE: begin
          valid_out    = 1'b1;
          wbs_out      = wbs_q;
          ni_out       = ni_q;
          memData_out  = rdata_q;
          calcData_out = calc_q;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with TIMEOUT=4: pass-through, load,
// store, timeout, stray ack, read+write priority and reset mid-access.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_in, mem_write_in, wbs_in, ni_in;
  logic [15:0] alu_result_in, write_data_in;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall, valid_out, wbs_out, ni_out, mem_err;
  logic [15:0] memData_out, calcData_out;

  int vecs = 0;
  int errs = 0;
  int stall_cnt;
  int req_cnt;

  memory_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .wbs_in(wbs_in), .ni_in(ni_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .valid_out(valid_out),
    .wbs_out(wbs_out), .memData_out(memData_out), .calcData_out(calcData_out),
    .ni_out(ni_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
    wbs_in = 1'b1; ni_in = 1'b1; alu_result_in = 16'h1234; write_data_in = 16'h0000;
    mem_rdata = 16'h0000; mem_ack = 1'b0;
    #12;
    chk("rst_vout", valid_out, 1'b0);
    chk("rst_calc", calcData_out, 16'h0000);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // ALU op passes straight through
    alu_result_in = 16'hFF00; wbs_in = 1'b1; ni_in = 1'b1;
    #1;
    chk("alu_calc", calcData_out, 16'hFF00);
    chk("alu_vout", valid_out, 1'b1);
    chk("alu_stall", stall, 1'b0);
    chk("alu_wbs", wbs_out, 1'b1);
    chk("alu_mem", memData_out, 16'h0000);
    step();
    chk("alu_req", mem_req, 1'b0);

    // Load, ack on third ACCESS cycle
    valid_in = 1'b1; mem_read_in = 1'b1; alu_result_in = 16'h0010; wbs_in = 1'b0; ni_in = 1'b1;
    write_data_in = 16'h5555;
    #1;
    stall_cnt = 0;
    if (stall) stall_cnt++;
    chk("ld_idle_vout", valid_out, 1'b0);
    step();
    if (stall) stall_cnt++;
    chk("ld_req", mem_req, 1'b1);
    chk("ld_we", mem_we, 1'b0);
    chk("ld_addr", mem_addr, 16'h0010);
    alu_result_in = 16'hDEAD;
    step();
    if (stall) stall_cnt++;
    chk("ld_addr_hold", mem_addr, 16'h0010);
    step();
    mem_ack = 1'b1; mem_rdata = 16'h00FF;
    #1;
    if (stall) stall_cnt++;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000; valid_in = 1'b0; mem_read_in = 1'b0;
    #1;
    chk("ld_stall_cycles", stall_cnt, 4);
    chk("ld_vout", valid_out, 1'b1);
    chk("ld_mem", memData_out, 16'h00FF);
    chk("ld_calc", calcData_out, 16'h0010);
    chk("ld_ni", ni_out, 1'b1);
    chk("ld_done_stall", stall, 1'b0);
    chk("ld_done_req", mem_req, 1'b0);
    step();
    chk("ld_idle_after", valid_out, 1'b0);

    // Store with immediate ack; returned data must be discarded
    valid_in = 1'b1; mem_write_in = 1'b1; alu_result_in = 16'h0020; write_data_in = 16'hAAAA;
    wbs_in = 1'b1; ni_in = 1'b0;
    #1;
    chk("st_idle_stall", stall, 1'b1);
    step();
    chk("st_we", mem_we, 1'b1);
    chk("st_addr", mem_addr, 16'h0020);
    chk("st_wdata", mem_wdata, 16'hAAAA);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0; valid_in = 1'b0; mem_write_in = 1'b0;
    #1;
    chk("st_vout", valid_out, 1'b1);
    chk("st_mem", memData_out, 16'h0000);
    chk("st_calc", calcData_out, 16'h0020);
    chk("st_wbs", wbs_out, 1'b1);
    chk("st_err", mem_err, 1'b0);
    step();

    // Timeout: never ack
    valid_in = 1'b1; mem_read_in = 1'b1; alu_result_in = 16'h0030;
    #1;
    req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_req) req_cnt++;
    end
    step();
    valid_in = 1'b0; mem_read_in = 1'b0;
    #1;
    chk("to_req_cycles", req_cnt, 4);
    chk("to_req_low", mem_req, 1'b0);
    chk("to_err", mem_err, 1'b1);
    chk("to_vout", valid_out, 1'b1);
    chk("to_mem", memData_out, 16'h0000);
    step();
    chk("to_err_sticky", mem_err, 1'b1);

    // Stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    chk("stray_req", mem_req, 1'b0);
    chk("stray_stall", stall, 1'b0);
    mem_ack = 1'b0;

    // Read and write together: write wins
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1; alu_result_in = 16'h0040;
    write_data_in = 16'hBEEF;
    step();
    chk("rw_we", mem_we, 1'b1);
    chk("rw_wdata", mem_wdata, 16'hBEEF);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_ack = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    #1;
    chk("rw_mem", memData_out, 16'h0000);
    step();

    // Reset in the middle of an access
    valid_in = 1'b1; mem_read_in = 1'b1; alu_result_in = 16'h0050;
    step();
    step();
    chk("rm_req_before", mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_req", mem_req, 1'b0);
    chk("rm_stall", stall, 1'b0);
    chk("rm_err", mem_err, 1'b0);
    chk("rm_vout", valid_out, 1'b0);
    valid_in = 1'b0; mem_read_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    valid_in = 1'b1; alu_result_in = 16'h7777;
    #1;
    chk("rm_idle_vout", valid_out, 1'b1);
    chk("rm_idle_calc", calcData_out, 16'h7777);
    chk("rm_idle_req", mem_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
